// File: rtl/writeback_unit.sv
// Writeback stage: joins in-order exwb entries with ALU/BRU/System results, writes the
// register file, raises redirect/invalidate on taken branches or traps, and counts retirements.
module writeback_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int RETIRE_CNT_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  // exwb entry stream
  input  logic                    exwb_tvalid,
  output logic                    exwb_tready,
  input  logic                    exwb_alu_cmd_vld,
  input  logic                    exwb_bru_cmd_vld,
  input  logic                    exwb_sys_cmd_vld,
  input  logic [4:0]              exwb_rd,
  input  logic                    exwb_rd_we,
  // ALU result
  input  logic                    alu_tvalid,
  output logic                    alu_tready,
  input  logic [XLEN-1:0]         alu_tdata,
  // BRU result {taken, target, link}
  input  logic                    bru_tvalid,
  output logic                    bru_tready,
  input  logic [2*XLEN:0]         bru_tdata,
  // System result {redirect, target, wdata}
  input  logic                    sys_tvalid,
  output logic                    sys_tready,
  input  logic [2*XLEN:0]         sys_tdata,
  // register write / forwarding {rd, we, wdata}
  output logic                    wbrf_tvalid,
  input  logic                    wbrf_tready,
  output logic [XLEN+5:0]         wbrf_tdata,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc,
  output logic                    invalidate,
  output logic                    retire,
  output logic [RETIRE_CNT_W-1:0] retire_cnt
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t         state_q, next_state;
  logic [FCW-1:0] flush_cnt_q, flush_cnt_d;

  logic            sel_sys, sel_bru, sel_alu;
  logic            unit_ok, out_free, fire, take_redirect;
  logic [XLEN-1:0] wdata_sel, target_sel;

  // Priority sys > bru > alu; with no flag the entry is a NOP needing no unit result.
  assign sel_sys = exwb_sys_cmd_vld;
  assign sel_bru = exwb_bru_cmd_vld && !exwb_sys_cmd_vld;
  assign sel_alu = exwb_alu_cmd_vld && !exwb_bru_cmd_vld && !exwb_sys_cmd_vld;

  assign out_free = !wbrf_tvalid || wbrf_tready;

  always_comb begin
    unit_ok       = 1'b1;
    wdata_sel     = '0;
    target_sel    = '0;
    take_redirect = 1'b0;
    if (sel_sys) begin
      unit_ok       = sys_tvalid;
      wdata_sel     = sys_tdata[XLEN-1:0];
      target_sel    = sys_tdata[2*XLEN-1:XLEN];
      take_redirect = sys_tdata[2*XLEN];
    end else if (sel_bru) begin
      unit_ok       = bru_tvalid;
      wdata_sel     = bru_tdata[XLEN-1:0];
      target_sel    = bru_tdata[2*XLEN-1:XLEN];
      take_redirect = bru_tdata[2*XLEN];
    end else if (sel_alu) begin
      unit_ok   = alu_tvalid;
      wdata_sel = alu_tdata;
    end
  end

  // Next-state and handshake logic; FLUSH swallows everything offered upstream.
  always_comb begin
    next_state  = state_q;
    flush_cnt_d = flush_cnt_q;
    fire        = 1'b0;
    exwb_tready = 1'b0;
    alu_tready  = 1'b0;
    bru_tready  = 1'b0;
    sys_tready  = 1'b0;
    case (state_q)
      ST_RUN: begin
        fire        = exwb_tvalid && unit_ok && out_free;
        exwb_tready = fire;
        alu_tready  = fire && sel_alu;
        bru_tready  = fire && sel_bru;
        sys_tready  = fire && sel_sys;
        if (fire && take_redirect) begin
          next_state  = ST_FLUSH;
          flush_cnt_d = FCW'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        exwb_tready = 1'b1;
        alu_tready  = 1'b1;
        bru_tready  = 1'b1;
        sys_tready  = 1'b1;
        if (flush_cnt_q == '0) next_state = ST_RUN;
        else                   flush_cnt_d = flush_cnt_q - FCW'(1);
      end
      default: next_state = ST_RUN;
    endcase
  end

  assign invalidate = (state_q == ST_FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= next_state;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // NOTE: all registered outputs use <= so they update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbrf_tvalid    <= 1'b0;
      wbrf_tdata     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      retire         <= 1'b0;
      retire_cnt     <= '0;
    end else begin
      retire         <= fire;
      redirect_valid <= fire && take_redirect;
      if (fire) begin
        wbrf_tvalid <= 1'b1;
        wbrf_tdata  <= {exwb_rd, exwb_rd_we && (exwb_rd != 5'd0), wdata_sel};
        retire_cnt  <= retire_cnt + RETIRE_CNT_W'(1);
        if (take_redirect) redirect_pc <= target_sel;
      end else if (wbrf_tready) begin
        wbrf_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit (XLEN=32, FLUSH_CYCLES=2, 4-bit retire counter).
module tb_writeback_unit;

  localparam int XLEN = 32;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            exwb_tvalid, exwb_tready;
  logic            exwb_alu_cmd_vld, exwb_bru_cmd_vld, exwb_sys_cmd_vld;
  logic [4:0]      exwb_rd;
  logic            exwb_rd_we;
  logic            alu_tvalid, alu_tready;
  logic [XLEN-1:0] alu_tdata;
  logic            bru_tvalid, bru_tready;
  logic [2*XLEN:0] bru_tdata;
  logic            sys_tvalid, sys_tready;
  logic [2*XLEN:0] sys_tdata;
  logic            wbrf_tvalid, wbrf_tready;
  logic [XLEN+5:0] wbrf_tdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            invalidate, retire;
  logic [CW-1:0]   retire_cnt;

  int checks = 0;
  int errors = 0;

  // {wbrf_tvalid, wbrf_tdata, retire, retire_cnt}
  logic [43:0] obs, exp_v;
  logic [3:0]  rdy, exp_rdy;

  writeback_unit #(.XLEN(XLEN), .FLUSH_CYCLES(2), .RETIRE_CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .exwb_tvalid(exwb_tvalid), .exwb_tready(exwb_tready),
    .exwb_alu_cmd_vld(exwb_alu_cmd_vld), .exwb_bru_cmd_vld(exwb_bru_cmd_vld),
    .exwb_sys_cmd_vld(exwb_sys_cmd_vld), .exwb_rd(exwb_rd), .exwb_rd_we(exwb_rd_we),
    .alu_tvalid(alu_tvalid), .alu_tready(alu_tready), .alu_tdata(alu_tdata),
    .bru_tvalid(bru_tvalid), .bru_tready(bru_tready), .bru_tdata(bru_tdata),
    .sys_tvalid(sys_tvalid), .sys_tready(sys_tready), .sys_tdata(sys_tdata),
    .wbrf_tvalid(wbrf_tvalid), .wbrf_tready(wbrf_tready), .wbrf_tdata(wbrf_tdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .invalidate(invalidate), .retire(retire), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    exwb_tvalid = 0; exwb_alu_cmd_vld = 0; exwb_bru_cmd_vld = 0; exwb_sys_cmd_vld = 0;
    exwb_rd = 0; exwb_rd_we = 0;
    alu_tvalid = 0; bru_tvalid = 0; sys_tvalid = 0;
  endtask

  task automatic offer(input logic a, input logic b, input logic s,
                       input logic [4:0] rd, input logic we);
    exwb_tvalid = 1; exwb_alu_cmd_vld = a; exwb_bru_cmd_vld = b; exwb_sys_cmd_vld = s;
    exwb_rd = rd; exwb_rd_we = we;
  endtask

  task automatic sample();
    obs = {wbrf_tvalid, wbrf_tdata, retire, retire_cnt};
    rdy = {exwb_tready, alu_tready, bru_tready, sys_tready};
  endtask

  task automatic test_reset();
    rst = 1; wbrf_tready = 1; idle(); alu_tdata = 0; bru_tdata = 0; sys_tdata = 0;
    repeat (2) step();
    sample();
    checks++;
    if ({obs, redirect_valid, redirect_pc, invalidate} !== '0) begin
      errors++; $display("FAIL reset_state got %h exp 0", {obs, redirect_valid, redirect_pc, invalidate});
    end
    rst = 0;
    step();
  endtask

  task automatic test_alu();
    offer(1, 0, 0, 5'd5, 1); alu_tvalid = 1; alu_tdata = 32'h0000_0042;
    #1; sample(); exp_rdy = 4'b1100;
    checks++;
    if (rdy !== exp_rdy) begin errors++; $display("FAIL alu_ready got %b exp %b", rdy, exp_rdy); end
    step(); idle(); sample();
    exp_v = {1'b1, 5'd5, 1'b1, 32'h42, 1'b1, 4'd1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL alu_wb got %h exp %h", obs, exp_v); end
    step(); sample();
    checks++;
    if ({obs[43], obs[4]} !== 2'b00) begin errors++; $display("FAIL alu_drain got %b exp 00", {obs[43], obs[4]}); end
  endtask

  task automatic test_rd0_nop();
    offer(1, 0, 0, 5'd0, 1); alu_tvalid = 1; alu_tdata = 32'h1234;
    step(); idle(); sample();
    exp_v = {1'b1, 5'd0, 1'b0, 32'h1234, 1'b1, 4'd2};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rd0_we got %h exp %h", obs, exp_v); end
    offer(0, 0, 0, 5'd7, 1); alu_tdata = 32'hffff_ffff;
    step(); idle(); sample();
    exp_v = {1'b1, 5'd7, 1'b1, 32'h0, 1'b1, 4'd3};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL nop_wb got %h exp %h", obs, exp_v); end
    step();
  endtask

  task automatic test_unit_stall();
    alu_tvalid = 1; alu_tdata = 32'h99; #1; sample();
    checks++;
    if (rdy !== 4'b0000) begin errors++; $display("FAIL orphan_result got %b exp 0000", rdy); end
    alu_tvalid = 0;
    offer(1, 0, 0, 5'd6, 1);
    for (int i = 0; i < 3; i++) begin
      #1; sample();
      checks++;
      if ({rdy, obs[43]} !== 5'b0) begin errors++; $display("FAIL unit_wait%0d got %b exp 00000", i, {rdy, obs[43]}); end
      step();
    end
    alu_tvalid = 1; alu_tdata = 32'h77; #1; sample();
    checks++;
    if (rdy !== 4'b1100) begin errors++; $display("FAIL unit_arrive got %b exp 1100", rdy); end
    step(); idle(); sample();
    exp_v = {1'b1, 5'd6, 1'b1, 32'h77, 1'b1, 4'd4};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL unit_wb got %h exp %h", obs, exp_v); end
    step();
  endtask

  task automatic test_redirect();
    offer(0, 1, 0, 5'd1, 1); bru_tvalid = 1; bru_tdata = {1'b1, 32'h200, 32'h104};
    #1; sample();
    checks++;
    if (rdy !== 4'b1010) begin errors++; $display("FAIL bru_ready got %b exp 1010", rdy); end
    step(); idle(); sample();
    exp_v = {1'b1, 5'd1, 1'b1, 32'h104, 1'b1, 4'd5};
    checks++;
    if ({obs, redirect_valid, redirect_pc, invalidate} !== {exp_v, 1'b1, 32'h200, 1'b1}) begin
      errors++; $display("FAIL jal_redirect got %h exp %h", {obs, redirect_valid, redirect_pc, invalidate},
                         {exp_v, 1'b1, 32'h200, 1'b1});
    end
    offer(1, 0, 0, 5'd9, 1); alu_tvalid = 1; alu_tdata = 32'hdead;
    #1; sample();
    checks++;
    if (rdy !== 4'b1111) begin errors++; $display("FAIL flush_ready got %b exp 1111", rdy); end
    step(); sample();
    checks++;
    if ({obs[43], obs[4:0], redirect_valid, invalidate} !== {1'b0, 1'b0, 4'd5, 1'b0, 1'b1}) begin
      errors++; $display("FAIL flush_drop got %b exp 00010101", {obs[43], obs[4:0], redirect_valid, invalidate});
    end
    idle(); step(); sample();
    checks++;
    if ({obs[43], obs[4:0], invalidate, redirect_pc} !== {1'b0, 1'b0, 4'd5, 1'b0, 32'h200}) begin
      errors++; $display("FAIL flush_end got %h exp %h", {obs[43], obs[4:0], invalidate, redirect_pc},
                         {1'b0, 1'b0, 4'd5, 1'b0, 32'h200});
    end
  endtask

  task automatic test_backpressure();
    wbrf_tready = 0;
    offer(1, 0, 0, 5'd3, 1); alu_tvalid = 1; alu_tdata = 32'h11;
    step();
    offer(1, 0, 0, 5'd4, 1); alu_tdata = 32'h22;
    #1; sample();
    checks++;
    if (rdy !== 4'b0000) begin errors++; $display("FAIL bp_noready got %b exp 0000", rdy); end
    for (int i = 0; i < 2; i++) begin
      step(); sample();
      exp_v = {1'b1, 5'd3, 1'b1, 32'h11, 1'b0, 4'd6};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL bp_hold%0d got %h exp %h", i, obs, exp_v); end
    end
    wbrf_tready = 1; #1; sample();
    checks++;
    if (rdy !== 4'b1100) begin errors++; $display("FAIL bp_release got %b exp 1100", rdy); end
    step(); idle(); sample();
    exp_v = {1'b1, 5'd4, 1'b1, 32'h22, 1'b1, 4'd7};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL bp_wb got %h exp %h", obs, exp_v); end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      offer(1, 0, 0, 5'(10 + i), 1); alu_tvalid = 1; alu_tdata = 32'h100 + i;
      step(); sample();
      exp_v = {1'b1, 5'(10 + i), 1'b1, 32'h100 + i, 1'b1, 4'(8 + i)};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL b2b%0d got %h exp %h", i, obs, exp_v); end
    end
    idle(); step();
  endtask

  task automatic test_sys_priority();
    offer(1, 0, 1, 5'd9, 1); alu_tvalid = 1; alu_tdata = 32'hffff;
    sys_tvalid = 1; sys_tdata = {1'b0, 32'h0, 32'habc};
    #1; sample();
    checks++;
    if (rdy !== 4'b1001) begin errors++; $display("FAIL sys_prio_ready got %b exp 1001", rdy); end
    step(); idle(); sample();
    exp_v = {1'b1, 5'd9, 1'b1, 32'habc, 1'b1, 4'd11};
    checks++;
    if ({obs, invalidate} !== {exp_v, 1'b0}) begin
      errors++; $display("FAIL sys_prio_wb got %h exp %h", {obs, invalidate}, {exp_v, 1'b0});
    end
    step();
  endtask

  task automatic test_reset_mid();
    wbrf_tready = 0;
    offer(0, 0, 1, 5'd2, 1); sys_tvalid = 1; sys_tdata = {1'b1, 32'h300, 32'h55};
    step(); idle(); sample();
    exp_v = {1'b1, 5'd2, 1'b1, 32'h55, 1'b1, 4'd12};
    checks++;
    if ({obs, redirect_valid, redirect_pc, invalidate} !== {exp_v, 1'b1, 32'h300, 1'b1}) begin
      errors++; $display("FAIL trap_redirect got %h exp %h", {obs, redirect_valid, redirect_pc, invalidate},
                         {exp_v, 1'b1, 32'h300, 1'b1});
    end
    step(); sample();
    checks++;
    if ({obs[43], invalidate} !== 2'b11) begin errors++; $display("FAIL stall_in_flush got %b exp 11", {obs[43], invalidate}); end
    rst = 1; #1; sample();
    checks++;
    if ({obs, redirect_valid, redirect_pc, invalidate} !== '0) begin
      errors++; $display("FAIL reset_mid got %h exp 0", {obs, redirect_valid, redirect_pc, invalidate});
    end
    wbrf_tready = 1;
    step(); rst = 0; step();
  endtask

  task automatic test_wrap();
    offer(0, 0, 0, 5'd0, 0);
    for (int i = 0; i < 15; i++) step();
    sample();
    checks++;
    if (obs[4:0] !== {1'b1, 4'd15}) begin errors++; $display("FAIL cnt_max got %b exp 11111", obs[4:0]); end
    step(); idle(); sample();
    checks++;
    if (obs[4:0] !== {1'b1, 4'd0}) begin errors++; $display("FAIL cnt_wrap got %b exp 10000", obs[4:0]); end
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_rd0_nop();
    test_unit_stall();
    test_redirect();
    test_backpressure();
    test_back_to_back();
    test_sys_priority();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
